// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory: byte/half/word access, RMW for sub-word stores.
// Optional LSU_MISALIGN_CHECK_EN: fault misaligned half/word accesses instead of aligning them down.

module lsu_lane_merge (
  input  logic       wr_sel,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] out_byte
);
  assign out_byte = wr_sel ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_fault,
  output logic                     mem_write_en,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [ADDRESS_WIDTH+1:0] mem_address,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);
  localparam int AW        = ADDRESS_WIDTH + 2;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;

  // Incoming request decode (only meaningful while IDLE)
  logic [1:0]    in_size;
  logic          in_illegal;
  logic          in_misalign;
  logic          in_fault;
  logic [AW-1:0] in_addr;

  assign in_size    = req_funct3[1:0];
  assign in_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_CHECK_EN
  assign in_misalign = ((in_size == 2'b01) && req_addr[0]) ||
                       ((in_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign in_addr     = req_addr;
`else
  assign in_misalign = 1'b0;
  always_comb begin
    in_addr = req_addr;
    case (in_size)
      2'b01:   in_addr = {req_addr[AW-1:1], 1'b0};
      2'b10:   in_addr = {req_addr[AW-1:2], 2'b00};
      default: in_addr = req_addr;
    endcase
  end
`endif

  assign in_fault = in_illegal | in_misalign;

  // Store path: replicate right-aligned data across lanes, then pick lanes to overwrite
  logic [NUM_LANES-1:0]  lane_wr;
  logic [DATA_WIDTH-1:0] store_rep;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    lane_wr   = '0;
    store_rep = req_q.wdata;
    case (req_q.funct3[1:0])
      2'b00: begin
        lane_wr[req_q.addr[1:0]] = 1'b1;
        store_rep = {NUM_LANES{req_q.wdata[7:0]}};
      end
      2'b01: begin
        lane_wr   = req_q.addr[1] ? NUM_LANES'(4'b1100) : NUM_LANES'(4'b0011);
        store_rep = {(NUM_LANES/2){req_q.wdata[15:0]}};
      end
      default: begin
        lane_wr   = '1;
        store_rep = req_q.wdata;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_lane_merge u_lane (
      .wr_sel  (lane_wr[i]),
      .old_byte(word_q[8*i +: 8]),
      .new_byte(store_rep[8*i +: 8]),
      .out_byte(merged[8*i +: 8])
    );
  end

  // Load path: halfword accesses are aligned here, so a byte shift serves both sizes
  logic [15:0]           rd_shift;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    rd_shift  = 16'(mem_read_data >> {req_q.addr[1:0], 3'b000});
    load_data = mem_read_data;
    case (req_q.funct3)
      3'b000:  load_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: load_data = mem_read_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    word_d       = word_q;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.we     = req_we;
          req_d.funct3 = req_funct3;
          req_d.addr   = in_addr;
          req_d.wdata  = req_wdata;
          if (in_fault) begin
            state_d      = RESP;
            resp_fault_d = 1'b1;
          end else if (!req_we || (in_size != 2'b10)) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        word_d = mem_read_data;
        if (req_q.we) begin
          state_d = WRITE;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_data;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      word_q       <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      word_q       <= word_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = resp_rdata_q;
  assign resp_fault     = resp_fault_q;
  assign mem_write_en   = (state_q == WRITE);
  assign mem_write_data = mem_write_en ? merged : '0;
  assign mem_address    = ((state_q == READ) || (state_q == WRITE)) ?
                          {req_q.addr[AW-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-during-write sequence, random traffic vs a byte-level model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [7:0]  mem_address;
  logic [31:0] mem_read_data;

  load_store_unit #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_address(mem_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Attached data memory and the reference model's own copy
  logic [31:0] mem    [64];
  logic [31:0] refmem [64];
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write_en) mem[mem_address[7:2]] <= mem_write_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level behavioural model; updates refmem for stores
  function automatic void ref_exec(input logic we, input logic [2:0] f3, input logic [7:0] a,
                                   input logic [31:0] wd, output logic [31:0] rd,
                                   output logic flt, output int lat);
    int nbytes, ea, off;
    logic [31:0] w, v;
    nbytes = 1 << f3[1:0];
    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    ea  = int'(a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (!flt && (ea % nbytes) != 0) flt = 1'b1;
`else
    if (!flt) ea = ea - (ea % nbytes);
`endif
    rd  = 32'h0;
    lat = 1;
    if (flt) return;
    off = ea % 4;
    w   = refmem[ea / 4];
    if (we) begin
      for (int k = 0; k < nbytes; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
      refmem[ea / 4] = w;
      lat = (nbytes == 4) ? 2 : 3;
    end else begin
      v = w >> (8 * off);
      if (nbytes == 1)      rd = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (nbytes == 2) rd = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                  rd = w;
      lat = 2;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output int wr_cnt, output logic [31:0] wr_data,
                        output logic [7:0] wr_addr);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 99; wr_cnt = 0; rd = 32'hX; flt = 1'bX; wr_data = 32'h0; wr_addr = 8'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_write_en) begin wr_cnt++; wr_data = mem_write_data; wr_addr = mem_address; end
      if (mem_address[1:0] != 2'b00) chk("addr_low_bits", {30'h0, mem_address[1:0]}, 32'h0);
      if (resp_valid) begin lat = c; rd = resp_rdata; flt = resp_fault; break; end
    end
    @(negedge clk);
    chk("post_valid", {31'h0, resp_valid}, 32'h0);
    chk("post_rdata", resp_rdata, 32'h0);
    chk("post_ready", {31'h0, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_flt;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [2:0] f3, input logic [7:0] a,
                              input logic [31:0] wd, input logic [31:0] erd, input logic eflt,
                              input int elat, input int ewr, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rd = erd; v.exp_flt = eflt;
    v.exp_lat = elat; v.exp_wr = ewr; v.exp_wdata = ewd;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd, wr_data;
    logic [7:0]  wr_addr;
    logic        flt, mflt, seen;
    int          lat, mlat, wr_cnt;
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  a;
    logic [31:0] wd;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h8899AABB; mem[1] = 32'h11223344; mem[2] = 32'hDEADBEEF; mem[4] = 32'h01020304;
    for (int i = 0; i < 64; i++) refmem[i] = mem[i];

    #2;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_write_en}, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_address}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    add(0, 3'd2, 8'h00, 0, 32'h8899AABB, 0, 2, 0, 0);
    add(0, 3'd0, 8'h07, 0, 32'h00000011, 0, 2, 0, 0);
    add(0, 3'd0, 8'h04, 0, 32'h00000044, 0, 2, 0, 0);
    add(0, 3'd4, 8'h05, 0, 32'h00000033, 0, 2, 0, 0);
    add(1, 3'd2, 8'h04, 32'h80FF0000, 0, 0, 2, 1, 32'h80FF0000);
    add(0, 3'd1, 8'h06, 0, 32'hFFFF80FF, 0, 2, 0, 0);
    add(0, 3'd5, 8'h06, 0, 32'h000080FF, 0, 2, 0, 0);
    add(0, 3'd0, 8'h06, 0, 32'hFFFFFFFF, 0, 2, 0, 0);
    add(1, 3'd0, 8'h09, 32'h000000A5, 0, 0, 3, 1, 32'hDEADA5EF);
    add(0, 3'd2, 8'h08, 0, 32'hDEADA5EF, 0, 2, 0, 0);
    add(1, 3'd2, 8'h0C, 32'h12345678, 0, 0, 2, 1, 32'h12345678);
    add(1, 3'd1, 8'h0E, 32'h0000CAFE, 0, 0, 3, 1, 32'hCAFE5678);
    add(0, 3'd2, 8'h0C, 0, 32'hCAFE5678, 0, 2, 0, 0);
    add(0, 3'd2, 8'h02, 0, CHK ? 32'h0 : 32'h8899AABB, CHK, CHK ? 1 : 2, 0, 0);
    add(0, 3'd3, 8'h00, 0, 0, 1, 1, 0, 0);
    add(1, 3'd6, 8'h0C, 32'hFFFFFFFF, 0, 1, 1, 0, 0);
    add(0, 3'd2, 8'h0C, 0, 32'hCAFE5678, 0, 2, 0, 0);
    add(1, 3'd1, 8'h0D, 32'h0000BEEF, 0, CHK, CHK ? 1 : 3, CHK ? 0 : 1, 32'hCAFEBEEF);
    add(0, 3'd2, 8'h0C, 0, CHK ? 32'hCAFE5678 : 32'hCAFEBEEF, 0, 2, 0, 0);
    add(0, 3'd1, 8'h03, 0, CHK ? 32'h0 : 32'hFFFF8899, CHK, CHK ? 1 : 2, 0, 0);
    add(0, 3'd5, 8'h02, 0, 32'h00008899, 0, 2, 0, 0);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat, wr_cnt, wr_data, wr_addr);
      ref_exec(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mflt, mlat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_fault", i), {31'h0, flt}, {31'h0, vecs[i].exp_flt});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_write_cycles", i), wr_cnt, vecs[i].exp_wr);
      if (vecs[i].exp_wr == 1) begin
        chk($sformatf("vec%0d_write_data", i), wr_data, vecs[i].exp_wdata);
        chk($sformatf("vec%0d_write_addr", i), {24'h0, wr_addr}, {24'h0, vecs[i].addr & 8'hFC});
      end
    end

    // Reset asserted while an sb sits in WRITE: no write may land
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 8'h10; req_wdata = 32'h00000077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_write_en) begin seen = 1'b1; break; end
    end
    chk("rst_mid_write_reached", {31'h0, seen}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_drop", {31'h0, mem_write_en}, 32'h0);
    chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_word4_kept", mem[4], 32'h01020304);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    do_req(1'b0, 3'd2, 8'h10, 32'h0, rd, flt, lat, wr_cnt, wr_data, wr_addr);
    ref_exec(1'b0, 3'd2, 8'h10, 32'h0, mrd, mflt, mlat);
    chk("rst_mid_reload_rdata", rd, 32'h01020304);
    chk("rst_mid_reload_latency", lat, 2);

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 31));
      wd = $urandom;
      do_req(we, f3, a, wd, rd, flt, lat, wr_cnt, wr_data, wr_addr);
      ref_exec(we, f3, a, wd, mrd, mflt, mlat);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_fault", i), {31'h0, flt}, {31'h0, mflt});
      chk($sformatf("rnd%0d_latency", i), lat, mlat);
      chk($sformatf("rnd%0d_write_cycles", i), wr_cnt, (we && !mflt) ? 1 : 0);
    end
    for (int i = 0; i < 64; i++) chk($sformatf("final_word%0d", i), mem[i], refmem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
